// File: rtl/mult_unit.sv
// Iterative radix-2 shift-add multiplier for MULT/MULTU.
// Operands are latched as magnitudes, the product is accumulated over WIDTH
// cycles, and the sign is applied in a single fix-up cycle before done.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; hi/lo hold the last completed product
// RUN   | one multiplier bit per cycle, WIDTH cycles total
// FIX   | apply sign to the accumulator, register hi/lo
// DONE  | one-cycle done strobe; a new start is accepted here as well
module mult_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t             stateQ, stateD;
  logic               accept;
  logic [WIDTH-1:0]   mcand, mplier;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      count;
  logic               neg;

  logic [WIDTH-1:0]   magA, magB;
  logic [WIDTH:0]     addend, sum;
  logic [2*WIDTH-1:0] product;

  // Operand magnitudes, one shift-add step and the sign fix-up.
  always_comb begin
    magA    = (is_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    magB    = (is_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
    addend  = mplier[0] ? {1'b0, mcand} : '0;
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + addend;
    product = neg ? (~acc + (2*WIDTH)'(1)) : acc;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stateQ <= IDLE;
    else     stateQ <= stateD;
  end

  // Next-state logic; cancel always wins over start.
  always_comb begin
    stateD = stateQ;
    accept = 1'b0;
    case (stateQ)
      IDLE: begin
        if (start && !cancel) begin
          accept = 1'b1;
          stateD = RUN;
        end
      end
      RUN: begin
        if (cancel)            stateD = IDLE;
        else if (count == '0)  stateD = FIX;
      end
      FIX: begin
        if (cancel) stateD = IDLE;
        else        stateD = DONE;
      end
      DONE: begin
        if (start && !cancel) begin
          accept = 1'b1;
          stateD = RUN;
        end else begin
          stateD = IDLE;
        end
      end
      default: stateD = IDLE;
    endcase
  end

  // Datapath: operand latch, shift-add accumulation and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
      neg    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      busy <= (stateD == RUN) || (stateD == FIX);
      done <= (stateD == DONE);
      if (accept) begin
        mcand  <= magA;
        mplier <= magB;
        neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
        acc    <= '0;
        count  <= CW'(WIDTH - 1);
      end else if (stateQ == RUN && !cancel) begin
        acc    <= {sum, acc[WIDTH-1:1]};
        mplier <= mplier >> 1;
        count  <= count - CW'(1);
      end
      if (stateQ == FIX && !cancel) begin
        hi <= product[2*WIDTH-1:WIDTH];
        lo <= product[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_mult_unit.sv
// Self-checking bench for mult_unit: directed corner cases, control-path
// scenarios (ignored start, back-to-back, cancel, async reset) and random
// operands compared against an arithmetic reference product.
module tb_mult_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        cancel = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int nChecks = 0;
  int nPass   = 0;

  mult_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .a(a), .b(b), .cancel(cancel),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] refProduct(input logic [31:0] x, input logic [31:0] y,
                                             input logic s);
    longint     sx, sy;
    logic [63:0] ux, uy;
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
    ux = {32'h0, x};
    uy = {32'h0, y};
    return ux * uy;
  endfunction

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Called right after the start edge (#1); counts edges until done.
  task automatic waitDone(output int edges, output int busyCnt);
    busyCnt = busy ? 1 : 0;
    edges   = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      edges++;
      if (done) break;
      if (busy) busyCnt++;
    end
  endtask

  task automatic runOp(input string tag, input logic [31:0] x, input logic [31:0] y,
                       input logic s);
    int edges, busyCnt;
    logic [63:0] exp;
    exp = refProduct(x, y, s);
    @(negedge clk);
    a = x; b = y; is_signed = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom;
    waitDone(edges, busyCnt);
    checkVal({tag, " latency"}, edges, 33);
    checkVal({tag, " busy cycles"}, busyCnt, 33);
    checkVal({tag, " busy in done"}, busy, 0);
    checkVal({tag, " hi"}, hi, exp[63:32]);
    checkVal({tag, " lo"}, lo, exp[31:0]);
    @(posedge clk); #1;
    checkVal({tag, " done one cycle"}, done, 0);
  endtask

  initial begin
    int doneCnt, edges, busyCnt;
    logic [31:0] x, y;
    logic [31:0] corners [6];
    corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFE};

    #1;
    checkVal("reset busy", busy, 0);
    checkVal("reset done", done, 0);
    checkVal("reset hi", hi, 0);
    checkVal("reset lo", lo, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    runOp("7x6 u", 32'd7, 32'd6, 1'b0);
    checkVal("7x6 lo const", lo, 32'h2A);
    runOp("-3x5 s", 32'hFFFF_FFFD, 32'd5, 1'b1);
    checkVal("-3x5 hi const", hi, 32'hFFFF_FFFF);
    checkVal("-3x5 lo const", lo, 32'hFFFF_FFF1);
    runOp("maxu", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    checkVal("maxu hi const", hi, 32'hFFFF_FFFE);
    runOp("minxmin s", 32'h8000_0000, 32'h8000_0000, 1'b1);
    checkVal("minxmin hi const", hi, 32'h4000_0000);
    runOp("minx1 s", 32'h8000_0000, 32'd1, 1'b1);
    checkVal("minx1 lo const", lo, 32'h8000_0000);

    for (int n = 0; n < 24; n++) begin
      x = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      y = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      runOp($sformatf("rand%0d", n), x, y, 1'($urandom_range(0, 1)));
    end

    // Start while busy is ignored; operands must not be re-latched.
    @(negedge clk);
    a = 32'd3; b = 32'd4; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    doneCnt = 0;
    for (int i = 1; i <= 33; i++) begin
      @(posedge clk); #1;
      if (done) doneCnt++;
      if (i == 9)  begin start = 1'b1; a = 32'd9; b = 32'd9; end
      if (i == 10) start = 1'b0;
    end
    checkVal("ignored start done count", doneCnt, 1);
    checkVal("ignored start done at 33", done, 1);
    checkVal("ignored start lo", lo, 32'hC);
    checkVal("ignored start hi", hi, 32'h0);

    // Back-to-back: start during the DONE cycle.
    start = 1'b1; a = 32'd9; b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    checkVal("b2b done low", done, 0);
    checkVal("b2b busy", busy, 1);
    waitDone(edges, busyCnt);
    checkVal("b2b latency", edges, 33);
    checkVal("b2b lo", lo, 32'h51);
    doneCnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) doneCnt++;
    end
    checkVal("b2b no extra done", doneCnt, 0);

    // Cancel in RUN.
    @(negedge clk);
    a = 32'd5; b = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #1 cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    checkVal("cancel busy", busy, 0);
    doneCnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) doneCnt++;
    end
    checkVal("cancel no done", doneCnt, 0);
    checkVal("cancel hi kept", hi, 32'h0);
    checkVal("cancel lo kept", lo, 32'h51);

    // Cancel with start in IDLE: not accepted.
    @(negedge clk);
    a = 32'd7; b = 32'd7; start = 1'b1; cancel = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    checkVal("cancel+start busy", busy, 0);
    doneCnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) doneCnt++;
    end
    checkVal("cancel+start no done", doneCnt, 0);
    checkVal("cancel+start lo kept", lo, 32'h51);

    // Asynchronous reset mid-operation.
    @(negedge clk);
    a = 32'd100; b = 32'd100; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkVal("async rst busy", busy, 0);
    checkVal("async rst done", done, 0);
    checkVal("async rst hi", hi, 0);
    checkVal("async rst lo", lo, 0);
    @(negedge clk);
    rst = 1'b0;
    runOp("post rst 2x3", 32'd2, 32'd3, 1'b0);
    checkVal("post rst lo const", lo, 32'd6);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
